csr_counter_bank: RTL and testbench
===================================

# csr_counter_bank

Parametrised bank of wide event counters exposed through a CSR-style access port: cyc/wr/sel handshake with a low/high word select. It generalises the single CSR slave to CHANNELS counters plus an inhibit register, with a registered ack, a tear-free 64-bit read and per-channel overflow pulses. It sits beside the CSR decoder in the core and backs mcycle/minstret/hpmcounter-class registers.

## Interface

**Parameters**
- CHANNELS, 4: number of counters; legal range 1..31.
- WIDTH, 64: counter width; legal range 33..64.
- ADDR_W, $clog2(CHANNELS+1): width of the channel address.

**Ports**
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- cyc  in  1  access request; held by the master until ack.
- wr  in  1  1 = write, 0 = read; qualified by cyc.
- sel  in  1  0 = low word [31:0], 1 = high word [WIDTH-1:32].
- addr  in  ADDR_W  0..CHANNELS-1 select a counter; CHANNELS selects the inhibit register.
- data_i  in  32  write data.
- data_o  out  32  read data; valid while ack=1, held until the next accepted access.
- ack  out  1  one-cycle completion pulse.
- err  out  1  asserted with ack when addr > CHANNELS.
- inc  in  CHANNELS  per-channel increment event, one count per cycle.
- overflow  out  CHANNELS  one-cycle pulse when a counter wraps.

## Operation

**Reset** (rst low, asynchronous): counters, inhibit, shadow and shadow_valid cleared; data_o, ack, err and overflow all read 0; FSM goes to IDLE.

**FSM states: IDLE, ACK**
- IDLE → ACK on an edge with cyc=1. The access is accepted and executed at that edge, and ack/err/data_o are registered.
- ACK → IDLE unconditionally. cyc is ignored while in ACK.

**Counting**
- When inc[i] & ~inhibit[i], the counter increments modulo 2^WIDTH.
- A wrap from all-ones to 0 sets overflow[i]=1 for the following cycle.
- Loading all-ones by a write never pulses overflow.

**Writes**
- sel=0 replaces bits [31:0] of the counter.
- sel=1 replaces bits [WIDTH-1:32] with data_i[WIDTH-33:0].
- A write wins over a same-edge increment of that channel; the increment is lost.
- Writing a counter clears shadow_valid if shadow_ch matches that channel.

**Reads**
- data_o returns the value held before the accepting edge.
- A low-word read also latches the upper bits into shadow, sets shadow_ch=addr and sets shadow_valid.
- A high-word read returns shadow (zero-extended) when shadow_valid and shadow_ch==addr, then clears shadow_valid. Otherwise it returns the live upper bits.

**Inhibit register** (addr==CHANNELS)
- sel=0 reads and writes bits [CHANNELS-1:0]; the upper bits read 0.
- sel=1 reads 0; writes to it are ignored.

**Out-of-range address** (addr > CHANNELS): ack=1, err=1, data_o=0, no state change.

## Timing

- Latency: ack is high exactly one cycle after the accepting edge.
- Minimum access period is 2 cycles.
- The master drops cyc in the ack cycle. If cyc is still high after ACK, it is a new access.
- Increments never stall. A counter can change every cycle regardless of the FSM state.
- Low-to-high carry completes in the same edge; no partial-carry window exists.
- A reset during ACK clears ack immediately, and the access is lost.

## Structure

- Package csr_bank_pkg holds:
  - the state_t enum (IDLE, ACK),
  - the SEL_LO/SEL_HI constants,
  - the width legality check function.
- Sub-module csr_counter holds one channel:
  - WIDTH counter with half-word write, gated increment and registered overflow pulse.
  - It is instantiated CHANNELS times with a generate loop.
- The top level holds the FSM, the address decode, the inhibit register and the shadow logic.

## Test plan

- **Reset:** reset during traffic → all outputs 0; reads of ch0 lo/hi return 0x0 with ack a single cycle.
- **Tear-free read:**
  - Set ch1=0x0000_0000_FFFF_FFFF, inc[1] held high.
  - Read lo, then hi two cycles later.
  - Required: hi=0x0000_0000 (shadow), not 0x1. A second hi read returns the live 0x1.
- **Write priority and inhibit:**
  - Write ch2 lo=0x10 with inc[2]=1 on the same edge → counter 0x10.
  - Write inhibit=0b0100, then pulse inc[2] 5 times → ch2 stays 0x10.
- **Overflow:**
  - Write ch0 hi=0xFFFF_FFFF and lo=0xFFFF_FFFF, then one inc[0].
  - Required: overflow[0] high exactly one cycle and ch0 reads 0.
  - The write itself produces no overflow pulse.
- **Handshake and error:**
  - cyc held high for 6 cycles → exactly 3 ack pulses.
  - addr=CHANNELS+1 with CHANNELS=4 (addr=5) → ack=1, err=1, data_o=0, no counter change.

Source files
------------

// File: rtl/csr_bank_pkg.sv
// csr_bank_pkg
//   Shared types and constants for the CSR counter bank.
//   - state_t        : access handshake states (IDLE, ACK)
//   - SEL_LO/SEL_HI  : word select encodings for the 32-bit access port
//   - width_is_legal : parameter legality check for the counter width
package csr_bank_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  // Counters must be wider than one access word but fit in two.
  function automatic bit width_is_legal(input int width);
    return (width >= 33) && (width <= 64);
  endfunction

endpackage

// File: rtl/csr_counter.sv
// csr_counter
//   One wide event counter with half-word write access.
//   Ports:
//     clk      : clock, rising edge active
//     rst      : asynchronous active-low reset
//     wr_lo    : replace bits [31:0] with wdata
//     wr_hi    : replace bits [WIDTH-1:32] with wdata[WIDTH-33:0]
//     wdata    : write data
//     inc_en   : count one event this cycle (already gated by inhibit)
//     count    : current counter value
//     overflow : one-cycle pulse in the cycle after an all-ones -> 0 wrap
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // A write always beats an increment on the same edge, so the event is
  // dropped and a load of all-ones can never produce an overflow pulse.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (wr_lo) begin
      count_d[31:0] = wdata;
    end else if (wr_hi) begin
      count_d[WIDTH-1:32] = wdata[WIDTH-33:0];
    end else if (inc_en) begin
      count_d    = count_q + WIDTH'(1);
      overflow_d = &count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/csr_counter_bank.sv
// csr_counter_bank
//   CHANNELS wide event counters plus an inhibit register behind a 32-bit
//   CSR-style access port (cyc/wr/sel/addr, registered ack). A low-word read
//   snapshots the upper bits so the following high-word read of the same
//   channel is tear-free.
//   Ports:
//     clk, rst  : clock and asynchronous active-low reset
//     cyc, wr   : access request and direction (1 = write)
//     sel       : 0 = low word, 1 = high word
//     addr      : 0..CHANNELS-1 counter, CHANNELS inhibit, above = error
//     data_i    : write data
//     data_o    : read data, held until the next accepted access
//     ack, err  : one-cycle completion pulse, error flag for bad addresses
//     inc       : per-channel count events
//     overflow  : per-channel wrap pulses
module csr_counter_bank
  import csr_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cyc,
  input  logic                wr,
  input  logic                sel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic                ack,
  output logic                err,
  input  logic [CHANNELS-1:0] inc,
  output logic [CHANNELS-1:0] overflow
);

  localparam int HI_W = WIDTH - 32;

  if (!width_is_legal(WIDTH) || (CHANNELS < 1) || (CHANNELS > 31)) begin : g_param_check
    $error("csr_counter_bank: WIDTH must be 33..64 and CHANNELS 1..31");
  end

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         data_o_q, data_o_d;
  logic [CHANNELS-1:0] inhibit_q, inhibit_d;
  logic [HI_W-1:0]     shadow_q, shadow_d;
  logic [ADDR_W-1:0]   shadow_ch_q, shadow_ch_d;
  logic                shadow_valid_q, shadow_valid_d;

  logic                accept;
  logic                addr_is_inh;
  logic                addr_oor;
  logic                shadow_hit;
  logic [WIDTH-1:0]    count [CHANNELS];
  logic [WIDTH-1:0]    sel_count;
  logic [CHANNELS-1:0] wr_lo;
  logic [CHANNELS-1:0] wr_hi;
  logic [CHANNELS-1:0] inc_en;

  // cyc is only looked at in IDLE; the ACK cycle enforces a 2-cycle period.
  assign accept      = (state_q == IDLE) && cyc;
  assign addr_is_inh = (addr == ADDR_W'(CHANNELS));
  assign addr_oor    = (addr >  ADDR_W'(CHANNELS));
  assign shadow_hit  = shadow_valid_q && (shadow_ch_q == addr);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_lo[i]  = accept && wr && (sel == SEL_LO) && (addr == ADDR_W'(i));
    assign wr_hi[i]  = accept && wr && (sel == SEL_HI) && (addr == ADDR_W'(i));
    assign inc_en[i] = inc[i] & ~inhibit_q[i];

    csr_counter #(
      .WIDTH(WIDTH)
    ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .wr_lo    (wr_lo[i]),
      .wr_hi    (wr_hi[i]),
      .wdata    (data_i),
      .inc_en   (inc_en[i]),
      .count    (count[i]),
      .overflow (overflow[i])
    );
  end

  // Read mux over the counters; out-of-range addresses leave it at zero.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel_count = count[i];
      end
    end
  end

  // Access execution. Reads return the pre-edge value; counter writes
  // themselves happen inside the channel, here we only retire a stale shadow.
  always_comb begin
    state_d        = state_q;
    ack_d          = 1'b0;
    err_d          = 1'b0;
    data_o_d       = data_o_q;
    inhibit_d      = inhibit_q;
    shadow_d       = shadow_q;
    shadow_ch_d    = shadow_ch_q;
    shadow_valid_d = shadow_valid_q;
    case (state_q)
      IDLE: begin
        if (cyc) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (addr_oor) begin
            err_d    = 1'b1;
            data_o_d = '0;
          end else if (addr_is_inh) begin
            if (wr) begin
              if (sel == SEL_LO) begin
                inhibit_d = data_i[CHANNELS-1:0];
              end
            end else begin
              data_o_d = (sel == SEL_LO) ? 32'(inhibit_q) : '0;
            end
          end else if (wr) begin
            if (shadow_hit) begin
              shadow_valid_d = 1'b0;
            end
          end else if (sel == SEL_LO) begin
            data_o_d       = sel_count[31:0];
            shadow_d       = sel_count[WIDTH-1:32];
            shadow_ch_d    = addr;
            shadow_valid_d = 1'b1;
          end else if (shadow_hit) begin
            data_o_d       = 32'(shadow_q);
            shadow_valid_d = 1'b0;
          end else begin
            data_o_d = 32'(sel_count[WIDTH-1:32]);
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
      data_o_q       <= '0;
      inhibit_q      <= '0;
      shadow_q       <= '0;
      shadow_ch_q    <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
      data_o_q       <= data_o_d;
      inhibit_q      <= inhibit_d;
      shadow_q       <= shadow_d;
      shadow_ch_q    <= shadow_ch_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign data_o = data_o_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// tb_csr_counter_bank
//   Drives csr_counter_bank (4 channels, 64-bit) with directed scenarios and
//   random traffic. A behavioural model of the bank (plain 64-bit arithmetic
//   on an array of counters) predicts ack/err/data_o/overflow, compared on
//   every falling edge; directed scenarios also pin literal values.
module tb_csr_counter_bank;
  import csr_bank_pkg::*;

  localparam int CH = 4;
  localparam int W  = 64;
  localparam int AW = $clog2(CH + 1);

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          cyc    = 1'b0;
  logic          wr     = 1'b0;
  logic          sel    = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [31:0]   data_i = '0;
  logic [CH-1:0] inc    = '0;
  logic [31:0]   data_o;
  logic          ack;
  logic          err;
  logic [CH-1:0] overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_counter_bank #(
    .CHANNELS(CH),
    .WIDTH   (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cyc      (cyc),
    .wr       (wr),
    .sel      (sel),
    .addr     (addr),
    .data_i   (data_i),
    .data_o   (data_o),
    .ack      (ack),
    .err      (err),
    .inc      (inc),
    .overflow (overflow)
  );

  // ---------------- behavioural model ----------------
  logic [63:0]   mCnt   [CH];
  logic [63:0]   oldCnt [CH];
  logic [CH-1:0] mInh, oldInh, mOvf, wrHit;
  logic [31:0]   mShadow, mData;
  int            mShadowCh;
  logic          mShadowValid, mBusy, mAck, mErr, take;
  int            a;

  task automatic modelReset();
    for (int i = 0; i < CH; i++) mCnt[i] = 64'd0;
    mInh = '0; mOvf = '0; mShadow = '0; mData = '0; mShadowCh = 0;
    mShadowValid = 1'b0; mBusy = 1'b0; mAck = 1'b0; mErr = 1'b0;
  endtask

  task automatic modelStep();
    for (int i = 0; i < CH; i++) oldCnt[i] = mCnt[i];
    oldInh = mInh;
    wrHit  = '0;
    take   = !mBusy && cyc;
    mBusy  = take;
    mAck   = take;
    mErr   = 1'b0;
    a      = int'(addr);
    if (take) begin
      if (a > CH) begin
        mErr  = 1'b1;
        mData = 32'd0;
      end else if (a == CH) begin
        if (wr) begin
          if (!sel) mInh = data_i[CH-1:0];
        end else begin
          mData = sel ? 32'd0 : 32'(oldInh);
        end
      end else if (wr) begin
        wrHit[a] = 1'b1;
        if (!sel) mCnt[a] = {oldCnt[a][63:32], data_i};
        else      mCnt[a] = {data_i, oldCnt[a][31:0]};
        if (mShadowValid && mShadowCh == a) mShadowValid = 1'b0;
      end else if (!sel) begin
        mData        = oldCnt[a][31:0];
        mShadow      = oldCnt[a][63:32];
        mShadowCh    = a;
        mShadowValid = 1'b1;
      end else if (mShadowValid && mShadowCh == a) begin
        mData        = mShadow;
        mShadowValid = 1'b0;
      end else begin
        mData = oldCnt[a][63:32];
      end
    end
    for (int i = 0; i < CH; i++) begin
      mOvf[i] = 1'b0;
      if (!wrHit[i] && inc[i] && !oldInh[i]) begin
        mOvf[i] = (oldCnt[i] == 64'hFFFF_FFFF_FFFF_FFFF);
        mCnt[i] = oldCnt[i] + 64'd1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) modelReset();
      else      modelStep();
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_ack",      32'(ack),      32'(mAck));
      checkOutput("model_err",      32'(err),      32'(mErr));
      checkOutput("model_data_o",   data_o,        mData);
      checkOutput("model_overflow", 32'(overflow), 32'(mOvf));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        gotAck, gotErr;
  int          nAck;

  // One access: drive at a falling edge (with incV on the same edge), sample
  // in the ack cycle, then confirm ack has dropped one cycle later.
  task automatic applyStimulus(input logic w, input logic s, input logic [AW-1:0] ad,
                               input logic [31:0] d, input logic [CH-1:0] incV,
                               output logic [31:0] rdata, output logic a1, output logic e1);
    @(negedge clk);
    cyc = 1'b1; wr = w; sel = s; addr = ad; data_i = d; inc = incV;
    @(negedge clk);
    rdata = data_o; a1 = ack; e1 = err;
    cyc = 1'b0; wr = 1'b0; inc = '0;
    @(negedge clk);
    checkOutput("ack_single_cycle", 32'(ack), 32'd0);
  endtask

  task automatic doRead(input logic [AW-1:0] ad, input logic s, input logic [CH-1:0] incV,
                        input logic [31:0] expV, input string name);
    applyStimulus(1'b0, s, ad, 32'd0, incV, rd, gotAck, gotErr);
    checkOutput({name, "_ack"}, 32'(gotAck), 32'd1);
    checkOutput({name, "_err"}, 32'(gotErr), 32'd0);
    checkOutput(name, rd, expV);
  endtask

  task automatic doWrite(input logic [AW-1:0] ad, input logic s, input logic [31:0] d,
                         input logic [CH-1:0] incV);
    applyStimulus(1'b1, s, ad, d, incV, rd, gotAck, gotErr);
    checkOutput("write_ack", 32'(gotAck), 32'd1);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // reset state and first reads
    @(negedge clk);
    checkOutput("reset_ack",      32'(ack),      32'd0);
    checkOutput("reset_err",      32'(err),      32'd0);
    checkOutput("reset_data_o",   data_o,        32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    doRead(AW'(0), SEL_LO, 4'b0000, 32'd0, "reset_ch0_lo");
    doRead(AW'(0), SEL_HI, 4'b0000, 32'd0, "reset_ch0_hi");

    // tear-free 64-bit read across a low-to-high carry
    doWrite(AW'(1), SEL_HI, 32'd0, 4'b0000);
    doWrite(AW'(1), SEL_LO, 32'hFFFF_FFFF, 4'b0000);
    doRead(AW'(1), SEL_LO, 4'b0010, 32'hFFFF_FFFF, "tear_lo");
    doRead(AW'(1), SEL_HI, 4'b0000, 32'h0000_0000, "tear_hi_shadow");
    doRead(AW'(1), SEL_HI, 4'b0000, 32'h0000_0001, "tear_hi_live");

    // write beats same-edge increment, inhibit blocks counting
    doWrite(AW'(2), SEL_LO, 32'h10, 4'b0100);
    doRead(AW'(2), SEL_LO, 4'b0000, 32'h10, "wr_priority");
    doWrite(AW'(CH), SEL_LO, 32'h4, 4'b0000);
    repeat (5) begin
      @(negedge clk); inc = 4'b0100;
      @(negedge clk); inc = 4'b0000;
    end
    doRead(AW'(2), SEL_LO, 4'b0000, 32'h10, "inhibit_hold");
    doRead(AW'(CH), SEL_LO, 4'b0000, 32'h4, "inhibit_rd_lo");
    doRead(AW'(CH), SEL_HI, 4'b0000, 32'h0, "inhibit_rd_hi");
    doWrite(AW'(CH), SEL_LO, 32'h0, 4'b0000);

    // overflow pulse on wrap, none on load
    doWrite(AW'(0), SEL_HI, 32'hFFFF_FFFF, 4'b0000);
    doWrite(AW'(0), SEL_LO, 32'hFFFF_FFFF, 4'b0000);
    checkOutput("ovf_on_load", 32'(overflow), 32'd0);
    @(negedge clk); inc = 4'b0001;
    @(negedge clk); inc = 4'b0000;
    checkOutput("ovf_pulse", 32'(overflow), 32'h1);
    @(negedge clk);
    checkOutput("ovf_clear", 32'(overflow), 32'h0);
    doRead(AW'(0), SEL_LO, 4'b0000, 32'd0, "wrap_ch0_lo");
    doRead(AW'(0), SEL_HI, 4'b0000, 32'd0, "wrap_ch0_hi");

    // cyc held high for six cycles
    @(negedge clk);
    cyc = 1'b1; wr = 1'b0; sel = SEL_LO; addr = AW'(3);
    nAck = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) nAck++;
    end
    cyc = 1'b0;
    checkOutput("ack_count_6cyc", 32'(nAck), 32'd3);
    @(negedge clk);

    // out-of-range address
    applyStimulus(1'b0, SEL_LO, AW'(5), 32'd0, 4'b0000, rd, gotAck, gotErr);
    checkOutput("oor_ack",  32'(gotAck), 32'd1);
    checkOutput("oor_err",  32'(gotErr), 32'd1);
    checkOutput("oor_data", rd, 32'd0);
    applyStimulus(1'b1, SEL_LO, AW'(5), 32'h0000_DEAD, 4'b0000, rd, gotAck, gotErr);
    checkOutput("oor_wr_err", 32'(gotErr), 32'd1);
    doRead(AW'(1), SEL_LO, 4'b0000, 32'd0, "oor_no_change");

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      inc    = CH'($urandom) & CH'($urandom);
      cyc    = ($urandom_range(0, 2) == 0);
      wr     = 1'($urandom);
      sel    = 1'($urandom);
      addr   = AW'($urandom_range(0, 7));
      data_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    end
    @(negedge clk);
    cyc = 1'b0; wr = 1'b0; inc = '0;
    repeat (2) @(negedge clk);

    // reset in the ack cycle
    @(negedge clk);
    cyc = 1'b1; wr = 1'b0; sel = SEL_LO; addr = AW'(1);
    @(posedge clk);
    #1 checkOutput("pre_reset_ack", 32'(ack), 32'd1);
    #1 rst = 1'b0; cyc = 1'b0;
    #1;
    checkOutput("rst_ack",      32'(ack),      32'd0);
    checkOutput("rst_err",      32'(err),      32'd0);
    checkOutput("rst_data_o",   data_o,        32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    doRead(AW'(0), SEL_LO, 4'b0000, 32'd0, "post_rst_ch0_lo");
    doRead(AW'(0), SEL_HI, 4'b0000, 32'd0, "post_rst_ch0_hi");
    doRead(AW'(CH), SEL_LO, 4'b0000, 32'd0, "post_rst_inhibit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
